keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Scan controller for the 4x4 matrix keypad on the calculator board.
- Drives one row low at a time and samples the four columns through a two-flop synchronizer.
- Debounces the 16-key snapshot over whole sweeps and emits one key code per clean press.
- Output feeds the calculator input FSM in place of per-button debouncing.

Parameters:
- SCAN_DIV, 12000: clk cycles per row slot (1 ms at 12 MHz); legal range >= 4.
- DEB_SWEEPS, 5: consecutive identical sweep snapshots required to accept a press or a release; legal range >= 1.
- RPT_DELAY, 100: sweeps held before the first auto-repeat (used only with the optional feature).
- RPT_RATE, 25: sweeps between subsequent auto-repeats (used only with the optional feature).

Ports:
- clk, input, 1: 12 MHz system clock.
- rst_n, input, 1: asynchronous active-low reset.
- row_out, output, 4: row drive, active-low, exactly one bit low at all times.
- col_in, input, 4: column sense, active-low (pulled up), asynchronous.
- key_code, output, 4: code of the accepted key = row*4 + col.
- key_valid, output, 1: one-clk pulse when key_code is newly valid.
- key_held, output, 1: high while the accepted key remains pressed (debounced).

Behaviour:
- Reset values (async on rst_n low):
  - row_out = 4'b1110, so row 0 is driven.
  - key_code = 0, key_valid = 0, key_held = 0.
  - Divider, sweep snapshot, stable counter and synchronizer flops = 0 (synchronizer flops = 4'b1111).
  - FSM = S_IDLE.
- col_in passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Row timing:
  - The divider counts 0..SCAN_DIV-1.
  - On the last count of a slot, the synchronized columns are inverted and stored into snapshot bits [row*4 +: 4], then row_out rotates left to the next row (wrap 3 -> 0).
  - Row settle time is therefore SCAN_DIV-1 cycles minus 2 cycles of synchronizer latency.
- Sweep completion:
  - The row-3 sample asserts sweep_done for 1 cycle.
  - The snapshot is then compared with the previous sweep snapshot.
  - Equal: stable_cnt increments, saturating at DEB_SWEEPS.
  - Different: stable_cnt = 0.
  - The snapshot is copied to the previous-snapshot register.
- A stable snapshot is one where stable_cnt reaches DEB_SWEEPS on this sweep_done.
- FSM, evaluated only on sweep_done:
  - S_IDLE: wait for a stable snapshot with exactly one bit set. Then latch key_code = that bit index, pulse key_valid the next cycle, set key_held = 1, and go to S_HELD.
  - S_IDLE, other stable snapshots: zero bits or two or more bits are ignored and the FSM stays in S_IDLE (no ghost or multi-key codes).
  - S_HELD: a stable snapshot with the latched key bit clear goes to S_RELEASE.
  - S_HELD, other keys: additional keys pressed while held do not change key_code or pulse key_valid.
  - S_RELEASE: key_held = 0. Wait for a stable all-zero snapshot, then go to S_IDLE. A new key is accepted only after a full release.
- key_valid latency: exactly 1 clk after the sweep_done that completes the debounce; width 1 clk.
- key_code holds its value until the next accepted press.
- A bounce within a sweep window resets stable_cnt. Acceptance therefore needs DEB_SWEEPS clean sweeps after the last bounce.
- Reset mid-sweep: the scan restarts at row 0, no pulse is generated and the partial snapshot is discarded.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In S_HELD, a sweep counter starts at 0 on entry.
  - key_valid re-pulses with the same key_code when the counter reaches RPT_DELAY, then every RPT_RATE sweeps after that while the key is still held.
  - The counter clears on leaving S_HELD.
- Undefined: the repeat counter logic is absent and exactly one key_valid is generated per press.

Test Plan (SCAN_DIV=4, DEB_SWEEPS=3, RPT_DELAY=4, RPT_RATE=2):
- Reset check: hold rst_n low, then release -> row_out=1110, outputs 0; row_out cycles 1110->1101->1011->0111->1110 every 4 clk.
- Clean press: press key row 2 / col 1 (col_in[1]=0 while row_out[2]=0) -> one key_valid pulse with key_code=9 after the 3rd stable sweep; key_held=1.
- Release: release key 9 -> key_held falls after 3 stable empty sweeps; no key_valid.
- Bounce: toggle col_in every 5 clk for 40 clk, then hold -> no pulse during bounce; exactly one pulse 3 stable sweeps after toggling ends.
- Multi-key: press keys 0 and 15 together -> no key_valid; press key 5 while key 9 is held -> key_code stays 9, no pulse.
- Repeat (KEYPAD_REPEAT_EN defined): hold key 3 for 12 sweeps -> pulses at accept, accept+4, +6, +8, +10 sweeps; with the macro undefined -> a single pulse.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with sweep-level debounce and single-key acceptance.
// Define KEYPAD_REPEAT_EN to add auto-repeat of key_valid_o while a key is held.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 12000,
  parameter int DEB_SWEEPS = 5,
  parameter int RPT_DELAY  = 100,
  parameter int RPT_RATE   = 25
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [3:0] row_out_o,
  input  logic [3:0] col_in_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_SWEEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_RELEASE} state_t;

  logic [3:0]       colMeta_q, colSync_q;
  logic [DIV_W-1:0] divCnt_q;
  logic [1:0]       rowIdx_q;
  logic [3:0]       rowSel_q;
  logic [15:0]      snap_q, prevSnap_q;
  logic [CNT_W-1:0] stableCnt_q, stableCnt_d;
  logic             sweepDone_q;
  logic             lastCount, stable;
  logic [4:0]       hitCount;
  logic [3:0]       hitIdx;

  state_t           state_q, state_d;
  logic [3:0]       keyCode_q, keyCode_d;
  logic             keyValid_q, keyValid_d;
  logic             keyHeld_q, keyHeld_d;

  assign lastCount = (divCnt_q == DIV_W'(SCAN_DIV - 1));

  // Row scanning, snapshot capture and debounce bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      colMeta_q   <= 4'b1111;
      colSync_q   <= 4'b1111;
      divCnt_q    <= '0;
      rowIdx_q    <= 2'd0;
      rowSel_q    <= 4'b1110;
      snap_q      <= '0;
      prevSnap_q  <= '0;
      stableCnt_q <= '0;
      sweepDone_q <= 1'b0;
    end else begin
      colMeta_q   <= col_in_i;
      colSync_q   <= colMeta_q;
      sweepDone_q <= 1'b0;
      if (lastCount) begin
        divCnt_q                   <= '0;
        snap_q[{rowIdx_q, 2'b00} +: 4] <= ~colSync_q;
        rowIdx_q                   <= rowIdx_q + 2'd1;
        rowSel_q                   <= {rowSel_q[2:0], rowSel_q[3]};
        sweepDone_q                <= (rowIdx_q == 2'd3);
      end else begin
        divCnt_q <= divCnt_q + 1'b1;
      end
      if (sweepDone_q) begin
        prevSnap_q  <= snap_q;
        stableCnt_q <= stableCnt_d;
      end
    end
  end

  always_comb begin
    stableCnt_d = stableCnt_q;
    if (snap_q != prevSnap_q)
      stableCnt_d = '0;
    else if (stableCnt_q != CNT_W'(DEB_SWEEPS))
      stableCnt_d = stableCnt_q + 1'b1;
  end

  assign stable = sweepDone_q && (stableCnt_d == CNT_W'(DEB_SWEEPS));

  always_comb begin
    hitCount = '0;
    hitIdx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        hitCount = hitCount + 5'd1;
        hitIdx   = 4'(i);
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rptCnt_q, rptCnt_d;
  logic             rptArmed_q, rptArmed_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      keyCode_q  <= '0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rptCnt_q   <= '0;
      rptArmed_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
`ifdef KEYPAD_REPEAT_EN
      rptCnt_q   <= rptCnt_d;
      rptArmed_q <= rptArmed_d;
`endif
    end
  end

  // Key acceptance FSM; only moves on the cycle a full sweep has been captured.
  always_comb begin
    state_d    = state_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;
`ifdef KEYPAD_REPEAT_EN
    rptCnt_d   = rptCnt_q;
    rptArmed_d = rptArmed_q;
`endif
    if (sweepDone_q) begin
      case (state_q)
        S_IDLE: begin
          if (stable && hitCount == 5'd1) begin
            keyCode_d  = hitIdx;
            keyValid_d = 1'b1;
            keyHeld_d  = 1'b1;
            state_d    = S_HELD;
`ifdef KEYPAD_REPEAT_EN
            rptCnt_d   = '0;
            rptArmed_d = 1'b0;
`endif
          end
        end
        S_HELD: begin
          if (stable && !snap_q[keyCode_q]) begin
            keyHeld_d  = 1'b0;
            state_d    = S_RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rptCnt_d   = '0;
            rptArmed_d = 1'b0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rptCnt_d = rptCnt_q + 1'b1;
            if (rptCnt_d == (rptArmed_q ? RPT_W'(RPT_RATE) : RPT_W'(RPT_DELAY))) begin
              keyValid_d = 1'b1;
              rptCnt_d   = '0;
              rptArmed_d = 1'b1;
            end
`endif
          end
        end
        S_RELEASE: begin
          if (stable && snap_q == '0)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign row_out_o   = rowSel_q;
  assign key_code_o  = keyCode_q;
  assign key_valid_o = keyValid_q;
  assign key_held_o  = keyHeld_q;

endmodule
